// File: rtl/color_pkg.sv
// Shared codes for the colour-sense block: filter select, colour result and FSM states.
package color_pkg;

  localparam logic [1:0] FILT_RED   = 2'd0;
  localparam logic [1:0] FILT_BLUE  = 2'd1;
  localparam logic [1:0] FILT_CLEAR = 2'd2;
  localparam logic [1:0] FILT_GREEN = 2'd3;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  typedef enum logic [1:0] {
    S_GREEN,
    S_RED,
    S_BLUE,
    S_DECIDE
  } state_t;

endpackage

// File: rtl/edge_counter.sv
// Synchronises cs_out, detects rising edges and counts them with clear and saturation.
// Edge-to-count latency 3 cycles; no backpressure, clr wins over cnt_en.
module edge_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk_1MHz,
  input  logic             reset,
  input  logic             cs_out,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  logic meta_q, sync_q, sync_qq;
  logic rise;

  assign rise = sync_q & ~sync_qq;

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
      cnt     <= '0;
    end else begin
      meta_q  <= cs_out;
      sync_q  <= meta_q;
      sync_qq <= sync_q;
      if (clr)
        cnt <= '0;
      else if (cnt_en && rise && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/color_sense_fsm.sv
// Steps the sensor filter G->R->B, counts cs_out edges per window, classifies once per frame.
// Result 3*(SETTLE+WIN)+1 cycles per frame, no backpressure; COLOR_HYST_EN adds HYST_N-frame hysteresis on color.
module color_sense_fsm
  import color_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int WIN       = 500,
  parameter int SETTLE    = 8,
  parameter int MIN_COUNT = 4
`ifdef COLOR_HYST_EN
  , parameter int HYST_N  = 3
`endif
) (
  input  logic             clk_1MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             cs_out,
  output logic [1:0]       filter,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int PHASE = SETTLE + WIN;
  localparam int TW    = (PHASE > 1) ? $clog2(PHASE) : 1;

  state_t           state;
  logic [TW-1:0]    tick;
  logic [CNT_W-1:0] cnt, green_r, red_r;
  logic [1:0]       raw;
  logic             measuring, last, clr, cnt_en;

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, g, b);
    logic [CNT_W-1:0] mx;
    classify = COL_NONE;
    if (r > g && r > b)      classify = COL_RED;
    else if (g > r && g > b) classify = COL_GREEN;
    else if (b > r && b > g) classify = COL_BLUE;
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    if (mx < CNT_W'(MIN_COUNT)) classify = COL_NONE;
  endfunction

  assign measuring = (state != S_DECIDE);
  assign last      = (tick == TW'(PHASE - 1));
  assign cnt_en    = en && measuring && (tick >= TW'(SETTLE));
  // One counter serves all channels; it restarts in the first (settle) cycle of each measure state.
  assign clr       = !en || (measuring && (tick == '0));
  assign raw       = classify(red_r, green_r, cnt);

  edge_counter #(.CNT_W(CNT_W)) u_edge (
    .clk_1MHz (clk_1MHz),
    .reset    (reset),
    .cs_out   (cs_out),
    .clr      (clr),
    .cnt_en   (cnt_en),
    .cnt      (cnt)
  );

`ifdef COLOR_HYST_EN
  localparam int HW = $clog2(HYST_N + 1);
  logic [1:0]    run_val;
  logic [HW-1:0] run_len, run_next;

  always_comb begin
    run_next = HW'(1);
    if (raw == run_val && run_len != '0)
      run_next = (run_len == HW'(HYST_N)) ? run_len : run_len + 1'b1;
  end
`endif

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state       <= S_GREEN;
      tick        <= '0;
      filter      <= FILT_GREEN;
      color       <= COL_NONE;
      color_valid <= 1'b0;
      red_cnt     <= '0;
      green_cnt   <= '0;
      blue_cnt    <= '0;
      green_r     <= '0;
      red_r       <= '0;
`ifdef COLOR_HYST_EN
      run_val     <= COL_NONE;
      run_len     <= '0;
`endif
    end else if (!en) begin
      state       <= S_GREEN;
      tick        <= '0;
      filter      <= FILT_GREEN;
      color_valid <= 1'b0;
`ifdef COLOR_HYST_EN
      run_len     <= '0;
`endif
    end else begin
      color_valid <= 1'b0;
      case (state)
        S_GREEN: begin
          if (last) begin
            state  <= S_RED;
            filter <= FILT_RED;
            tick   <= '0;
          end else tick <= tick + 1'b1;
        end
        S_RED: begin
          if (tick == '0) green_r <= cnt;
          if (last) begin
            state  <= S_BLUE;
            filter <= FILT_BLUE;
            tick   <= '0;
          end else tick <= tick + 1'b1;
        end
        S_BLUE: begin
          if (tick == '0) red_r <= cnt;
          if (last) begin
            state  <= S_DECIDE;
            filter <= FILT_CLEAR;
            tick   <= '0;
          end else tick <= tick + 1'b1;
        end
        default: begin
          red_cnt     <= red_r;
          green_cnt   <= green_r;
          blue_cnt    <= cnt;
          color_valid <= 1'b1;
`ifdef COLOR_HYST_EN
          run_val <= raw;
          run_len <= run_next;
          if (run_next == HW'(HYST_N)) color <= raw;
`else
          color   <= raw;
`endif
          state  <= S_GREEN;
          filter <= FILT_GREEN;
          tick   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_sense_fsm.sv
// Randomised frame-level bench for color_sense_fsm with an edge-window reference model.
module tb_color_sense_fsm;

  localparam int CNT_W     = 6;
  localparam int WIN       = 500;
  localparam int SETTLE    = 8;
  localparam int MIN_COUNT = 4;
  localparam int HYST_N    = 3;
  localparam int P         = SETTLE + WIN;
  localparam int FULL      = 3 * P + 1;
  localparam int SATV      = (1 << CNT_W) - 1;

  logic             clk_1MHz = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b1;
  logic             cs_out = 1'b0;
  logic [1:0]       filter, color;
  logic             color_valid;
  logic [CNT_W-1:0] red_cnt, green_cnt, blue_cnt;

  int         checks = 0;
  int         errors = 0;
  logic       cs_prev = 1'b0;
  logic [1:0] model_color = 2'd0;
  int         hist[$];
  int         held[3];
  int         col_of[3] = '{2, 1, 3};

  always #5 clk_1MHz = ~clk_1MHz;

  color_sense_fsm #(
    .CNT_W(CNT_W), .WIN(WIN), .SETTLE(SETTLE), .MIN_COUNT(MIN_COUNT)
  ) dut (
    .clk_1MHz(clk_1MHz), .reset(reset), .en(en), .cs_out(cs_out),
    .filter(filter), .color(color), .color_valid(color_valid),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt)
  );

  task automatic apply_reset();
    @(negedge clk_1MHz);
    reset = 1'b1; cs_out = 1'b0; cs_prev = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    reset = 1'b0;
    model_color = 2'd0;
    hist.delete();
    for (int k = 0; k < 3; k++) held[k] = 0;
  endtask

  // Frame index 0 is the cycle in which the bench is positioned (at a negedge) on entry.
  // A rise driven in cycle fc is counted for channel k when fc+2 lies in that channel's count window.
  task automatic run_frame(input int pg, pr, pb, phg, phr, phb, stop_fc, input string name);
    int per[3], ph[3], acc[3];
    int ri, li, ef, m, n, arg, raw, bad_fc, bad_f, bad_v;
    bit fbad, vbad, same;
    logic v;
    per[0] = pg;  per[1] = pr;  per[2] = pb;
    ph[0]  = phg; ph[1]  = phr; ph[2]  = phb;
    for (int k = 0; k < 3; k++) acc[k] = 0;
    fbad = 0; vbad = 0; bad_fc = 0; bad_f = 0; bad_v = 0;
    for (int fc = 0; fc <= 3 * P && fc < stop_fc; fc++) begin
      ri = (fc < P) ? 0 : (fc < 2 * P) ? 1 : 2;
      li = fc - ri * P + ph[ri];
      v  = (per[ri] == 0) ? 1'b0 : ((li % per[ri]) < per[ri] / 2);
      if (v && !cs_prev)
        for (int k = 0; k < 3; k++)
          if (fc + 2 >= k * P + SETTLE && fc + 2 < (k + 1) * P) acc[k]++;
      cs_out = v; cs_prev = v;
      ef = (fc < P) ? 3 : (fc < 2 * P) ? 0 : (fc < 3 * P) ? 1 : 2;
      if (!fbad && filter !== 2'(ef)) begin fbad = 1; bad_fc = fc; bad_f = int'(filter); end
      @(posedge clk_1MHz); #1;
      if (fc < 3 * P && color_valid !== 1'b0 && !vbad) begin vbad = 1; bad_v = fc; end
      if (fc == 3 * P) begin
        for (int k = 0; k < 3; k++) if (acc[k] > SATV) acc[k] = SATV;
        m = -1; n = 0; arg = 0;
        for (int k = 0; k < 3; k++) if (acc[k] > m) begin m = acc[k]; arg = k; end
        for (int k = 0; k < 3; k++) if (acc[k] == m) n++;
        raw = (n == 1 && m >= MIN_COUNT) ? col_of[arg] : 0;
        hist.push_back(raw);
`ifdef COLOR_HYST_EN
        if (hist.size() >= HYST_N) begin
          same = 1;
          for (int j = hist.size() - HYST_N; j < hist.size(); j++) if (hist[j] != raw) same = 0;
          if (same) model_color = 2'(raw);
        end
`else
        same = 1;
        model_color = 2'(raw);
`endif
        for (int k = 0; k < 3; k++) held[k] = acc[k];
        checks++;
        if (color_valid !== 1'b1) begin errors++; $display("FAIL %s valid_at_end got %b want 1", name, color_valid); end
        checks++;
        if (color !== model_color) begin errors++; $display("FAIL %s color got %0d want %0d", name, color, model_color); end
        checks++;
        if (red_cnt !== CNT_W'(acc[1])) begin errors++; $display("FAIL %s red_cnt got %0d want %0d", name, red_cnt, acc[1]); end
        checks++;
        if (green_cnt !== CNT_W'(acc[0])) begin errors++; $display("FAIL %s green_cnt got %0d want %0d", name, green_cnt, acc[0]); end
        checks++;
        if (blue_cnt !== CNT_W'(acc[2])) begin errors++; $display("FAIL %s blue_cnt got %0d want %0d", name, blue_cnt, acc[2]); end
      end
      @(negedge clk_1MHz);
    end
    checks++;
    if (fbad) begin errors++; $display("FAIL %s filter at cycle %0d got %0d want %0d", name, bad_fc,
      bad_f, (bad_fc < P) ? 3 : (bad_fc < 2 * P) ? 0 : (bad_fc < 3 * P) ? 1 : 2); end
    checks++;
    if (vbad) begin errors++; $display("FAIL %s early_valid at cycle %0d got 1 want 0", name, bad_v); end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (filter !== 2'd3) begin errors++; $display("FAIL %s filter got %0d want 3", name, filter); end
    checks++;
    if (color !== 2'd0) begin errors++; $display("FAIL %s color got %0d want 0", name, color); end
    checks++;
    if (color_valid !== 1'b0) begin errors++; $display("FAIL %s valid got %b want 0", name, color_valid); end
    checks++;
    if (red_cnt !== '0 || green_cnt !== '0 || blue_cnt !== '0) begin
      errors++; $display("FAIL %s counts got %0d/%0d/%0d want 0/0/0", name, red_cnt, green_cnt, blue_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; cs_out = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    check_reset_values("reset");
    apply_reset();
  endtask

  task automatic test_red_dominant();
    run_frame(40, 10, 40, 0, 2, 0, FULL, "red_dom_a");
    run_frame(40, 10, 40, 7, 2, 13, FULL, "red_dom_b");
  endtask

  task automatic test_blue_and_equal();
    run_frame(20, 20, 8, 0, 0, 3, FULL, "blue_dom");
    run_frame(10, 10, 10, 0, 0, 0, FULL, "equal");
  endtask

  task automatic test_min_count();
    run_frame(0, 0, 0, 0, 0, 0, FULL, "held_low");
    run_frame(0, 120, 0, 0, 0, 0, FULL, "min_count_edge");
    run_frame(0, 150, 0, 0, 0, 0, FULL, "below_min_count");
  endtask

  task automatic test_saturate();
    run_frame(2, 40, 40, 0, 0, 0, FULL, "saturate");
    run_frame(2, 2, 2, 0, 1, 0, FULL, "saturate_tie");
    run_frame(2, 40, 40, 1, 5, 9, FULL, "saturate_green");
  endtask

  task automatic test_reset_mid();
    run_frame(40, 10, 40, 0, 2, 0, 700, "reset_mid_pre");
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_async");
    cs_out = 1'b0; cs_prev = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    reset = 1'b0;
    model_color = 2'd0;
    hist.delete();
    for (int k = 0; k < 3; k++) held[k] = 0;
    run_frame(40, 10, 40, 0, 2, 0, FULL, "reset_mid_post");
  endtask

  task automatic test_en_drop();
    bit vbad, fbad, hbad;
    vbad = 0; fbad = 0; hbad = 0;
    run_frame(20, 20, 8, 0, 0, 0, FULL, "en_prep");
    run_frame(40, 10, 40, 0, 0, 0, 1200, "en_drop_pre");
    en = 1'b0; cs_out = 1'b0; cs_prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_1MHz); #1;
      if (color_valid !== 1'b0) vbad = 1;
      if (filter !== 2'd3) fbad = 1;
      if (color !== model_color || red_cnt !== CNT_W'(held[1]) ||
          green_cnt !== CNT_W'(held[0]) || blue_cnt !== CNT_W'(held[2])) hbad = 1;
    end
    checks++;
    if (vbad) begin errors++; $display("FAIL en_drop valid got 1 want 0"); end
    checks++;
    if (fbad) begin errors++; $display("FAIL en_drop filter got %0d want 3", filter); end
    checks++;
    if (hbad) begin errors++; $display("FAIL en_drop hold got %0d %0d/%0d/%0d want %0d %0d/%0d/%0d",
      color, red_cnt, green_cnt, blue_cnt, model_color, held[1], held[0], held[2]); end
    @(negedge clk_1MHz);
    en = 1'b1;
    hist.delete();
    run_frame(40, 10, 40, 0, 2, 0, FULL, "en_resume");
  endtask

  task automatic test_hysteresis();
    apply_reset();
    run_frame(40, 10, 40, 0, 2, 0, FULL, "hyst_1a");
    run_frame(40, 10, 40, 3, 2, 1, FULL, "hyst_1b");
    run_frame(20, 20, 8, 0, 0, 0, FULL, "hyst_3a");
    run_frame(20, 20, 8, 5, 9, 2, FULL, "hyst_3b");
    run_frame(20, 20, 8, 1, 1, 4, FULL, "hyst_3c");
  endtask

  task automatic test_random();
    int pp[3], qq[3];
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 3; k++) begin
        pp[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 160));
        qq[k] = int'($urandom_range(0, 160));
      end
      run_frame(pp[0], pp[1], pp[2], qq[0], qq[1], qq[2], FULL, "random");
    end
  endtask

  initial begin
    test_reset();
    test_red_dominant();
    test_blue_and_equal();
    test_min_count();
    test_saturate();
    test_reset_mid();
    test_en_drop();
    test_hysteresis();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_sense_fsm.md
Name: color_sense_fsm

Overview:
- Parametrised successor to the single-shot colour-detect FSM.
- Cycles the colour-sensor photodiode filter select through green → red → blue. After each filter switch it waits out a settle time, then counts rising edges of the sensor frequency output (cs_out) over a fixed window.
- At the end of each frame it classifies the colour and raises a one-cycle result strobe.
- Sits between the sensor pins and the bot's decision logic; adds reset, enable, saturating counts, exported counts and an explicit "no object" rule.

Parameters:
- CNT_W, 10, width of each per-channel edge counter and exported count.
- WIN, 500, counting window per filter in clk_1MHz cycles (same for all channels so raw counts compare fairly).
- SETTLE, 8, cycles ignored after each filter change before counting starts.
- MIN_COUNT, 4, winning count below this gives color 0 (no object).
- HYST_N, 3, consecutive identical classifications needed to update color (used only with COLOR_HYST_EN).

Ports:
- clk_1MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable
- cs_out  in  1  sensor frequency output, asynchronous to clk_1MHz
- filter  out  2  sensor S2/S3 select: 0 red, 1 blue, 2 clear, 3 green
- color  out  2  0 none/ambiguous, 1 red, 2 green, 3 blue
- color_valid  out  1  one-cycle pulse per completed frame
- red_cnt, green_cnt, blue_cnt  out  CNT_W each  counts snapshotted at the end of the frame

Behaviour:
- Reset (async, active-high):
  - filter=3, color=0, color_valid=0, all exported counts 0.
  - Internal counters 0, synchroniser flops 0, FSM in S_GREEN with settle counter 0.
  - Reset mid-frame aborts the frame; nothing is latched.
- Input conditioning:
  - cs_out passes through a 2-flop synchroniser, then a rising-edge detector (sync_q & ~sync_qq).
  - An edge counts only if detected in a count-phase cycle.
  - Edge-to-count latency is 3 cycles; this latency is accepted, not compensated.
- FSM states: S_GREEN (filter=3), S_RED (filter=0), S_BLUE (filter=1), S_DECIDE (filter=2).
  - Each measure state lasts SETTLE+WIN cycles: the first SETTLE are settle, the remaining WIN are count phase. The state then advances.
  - S_DECIDE lasts 1 cycle, then returns to S_GREEN.
  - Frame length = 3*(SETTLE+WIN)+1 cycles (1525 at defaults).
- Counters:
  - Each channel counter clears on entry to its state.
  - Counters saturate at 2^CNT_W−1; they never wrap.
- S_DECIDE actions:
  - Snapshot the three counts to the *_cnt outputs.
  - Compute raw classification:
    - 1 if R>G and R>B.
    - 2 if G>R and G>B.
    - 3 if B>R and B>G.
    - Otherwise 0; any tie for the maximum is ambiguous.
    - Forced to 0 if the maximum count < MIN_COUNT.
  - color updates (see Optional Feature); color_valid=1 for this cycle only.
- en:
  - Sampled every cycle.
  - en=0 forces the FSM to S_GREEN and clears the settle counter and channel counters on the next edge; filter=3.
  - color and *_cnt hold their values; no color_valid pulses.
  - Re-asserting en starts a full fresh frame.
- Simultaneous events: reset dominates en; en=0 dominates a pending S_DECIDE (no pulse, no update).
- Outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: COLOR_HYST_EN.
- Defined:
  - A run counter tracks consecutive frames with identical raw classification.
  - color updates only when the run reaches HYST_N, then holds until another value reaches HYST_N.
  - The run counter resets on reset and on en=0.
  - color_valid still pulses every frame.
- Undefined: color = raw classification every S_DECIDE; no run counter is synthesised.

Decomposition:
- Package color_pkg holds:
  - Filter codes FILT_RED=2'd0, FILT_BLUE=2'd1, FILT_CLEAR=2'd2, FILT_GREEN=2'd3.
  - Color codes COL_NONE=0, COL_RED=1, COL_GREEN=2, COL_BLUE=3.
  - The FSM state enum.
- One sub-module, edge_counter: synchroniser + edge detect + clearable saturating counter with a count-enable input. Instantiated once and shared across channels, with a per-state clear.

Test Plan:
- Reset asserted mid-S_RED → outputs go to reset values immediately (async); after release, first color_valid arrives 1525 cycles later.
- cs_out period 10 cycles under red and 40 under green/blue → red_cnt=50, green_cnt=12 or 13, blue_cnt=12 or 13, color=1, one valid pulse per 1525 cycles.
- cs_out period 8 under blue, 20 otherwise → blue_cnt≈62, color=3; with period 10 on all filters → equal counts, color=0.
- cs_out held low → all counts 0, color=0 (below MIN_COUNT); cs_out period 2 with CNT_W=6 → counts saturate at 63, no wrap.
- en dropped for 100 cycles mid-S_BLUE → no pulse, color and counts held, filter=3; next pulse 1525 cycles after en rises.
- With COLOR_HYST_EN and HYST_N=3: frames classify 1,1,3,3,3 → color stays 0, 0, 0, 0, then 3 after the fifth frame. Without the macro → color follows 1,1,3,3,3.
